draw_wave: RTL and testbench

Overlay stage directly downstream of the background drawer in the VGA pipeline. It captures a triggered record of 8-bit ADC samples into a double-buffered sample memory and draws the completed record as a continuous trace over the incoming background stream. Buffers swap only during vertical blanking, so a displayed frame never shows a partially written record.

---
 rtl/vga_if.sv | 20 ++
 rtl/draw_wave.sv | 229 ++++++++++++++++++++++
 tb/tb_draw_wave.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_if.sv
// vga_if: one pixel of VGA timing plus colour, as passed between drawing stages.
//   hcount, vcount : pixel position
//   hsync, vsync   : sync pulses
//   hblnk, vblnk   : blanking flags
//   rgb            : 12-bit colour
// The master/out views drive the bundle; the slave/in views receive it.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_wave.sv
// draw_wave: captures a triggered record of 8-bit ADC samples into a
// double-buffered memory and overlays the last complete record as a trace on
// the background VGA stream. Buffers swap only on a vblnk rising edge.
// Ports:
//   clk, rst      : pixel clock, synchronous active-high reset
//   in            : background timing and rgb
//   out           : same stream delayed 2 clocks, trace overlaid on rgb
//   sample_valid  : strobe qualifying sample_data
//   sample_data   : unsigned ADC sample
//   trig_level    : rising-edge trigger threshold
//   hold          : blocks buffer swaps while high
//   trig_seen     : one-cycle pulse when a capture starts (registered)
module draw_wave #(
    parameter int          NSAMPLES     = 800,
    parameter int          Y_OFF        = 150,
    parameter logic [11:0] TRACE_RGB    = 12'h0_f_0,
    parameter int          AUTO_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    vga_if.in          in,
    vga_if.out         out,
    input  logic       sample_valid,
    input  logic [7:0] sample_data,
    input  logic [7:0] trig_level,
    input  logic       hold,
    output logic       trig_seen
);

    localparam int AW = $clog2(NSAMPLES);
    localparam int TW = $clog2(AUTO_TIMEOUT);

    typedef enum logic [1:0] {ARM, WAIT_TRIG, CAPTURE, FULL} cap_state_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } pixel_t;

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    cap_state_t    state_q, state_d;
    logic [7:0]    prev_q, prev_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          ptr_q, ptr_d;       // 0: front = mem0, back = mem1
    logic          fv_q, fv_d;         // front buffer holds a complete record
    logic          trig_d;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic          vblnk_rise;

    pixel_t        s0;

    // s0.vblnk is last clock's in.vblnk, so this is the rising edge.
    assign vblnk_rise = in.vblnk && !s0.vblnk;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARM;
            prev_q    <= '0;
            tcnt_q    <= '0;
            wr_addr_q <= '0;
            ptr_q     <= 1'b0;
            fv_q      <= 1'b0;
            trig_seen <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            tcnt_q    <= tcnt_d;
            wr_addr_q <= wr_addr_d;
            ptr_q     <= ptr_d;
            fv_q      <= fv_d;
            trig_seen <= trig_d;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        tcnt_d    = tcnt_q;
        wr_addr_d = wr_addr_q;
        ptr_d     = ptr_q;
        fv_d      = fv_q;
        trig_d    = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = wr_addr_q;

        unique case (state_q)
            ARM: begin
                // First accepted sample only primes prev.
                if (sample_valid) begin
                    prev_d  = sample_data;
                    tcnt_d  = '0;
                    state_d = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                if (sample_valid) begin
                    prev_d = sample_data;
                    if ((prev_q < trig_level && sample_data >= trig_level) ||
                        tcnt_q == TW'(AUTO_TIMEOUT - 1)) begin
                        // Triggering sample becomes index 0 of the record.
                        wr_en     = 1'b1;
                        wr_idx    = '0;
                        wr_addr_d = AW'(1);
                        trig_d    = 1'b1;
                        state_d   = CAPTURE;
                    end else begin
                        // Cannot pass AUTO_TIMEOUT-1: that value triggers.
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            CAPTURE: begin
                if (sample_valid) begin
                    wr_en     = 1'b1;
                    wr_addr_d = wr_addr_q + AW'(1);
                    if (wr_addr_q == AW'(NSAMPLES - 1)) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (vblnk_rise && !hold) begin
                    ptr_d     = ~ptr_q;
                    fv_d      = 1'b1;
                    wr_addr_d = '0;
                    state_d   = ARM;
                end
            end
            default: state_d = ARM;
        endcase
    end

    // ------------------------------------------------------------------
    // Sample memory: two synchronous-read arrays, back written, front read
    // ------------------------------------------------------------------
    logic [7:0]    mem0 [NSAMPLES];
    logic [7:0]    mem1 [NSAMPLES];
    logic [7:0]    rd0, rd1;
    logic          rd_sel;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    assign rd_en   = in.hcount < 11'(NSAMPLES);
    assign rd_addr = in.hcount[AW-1:0];

    // NOTE: the arrays and their read registers have no reset so they map onto
    // block RAM; front_valid hides whatever they hold until the first swap.
    always_ff @(posedge clk) begin
        if (wr_en && ptr_q) begin
            mem0[wr_idx] <= sample_data;
        end
        if (wr_en && !ptr_q) begin
            mem1[wr_idx] <= sample_data;
        end
        if (rd_en) begin
            rd0 <= mem0[rd_addr];
            rd1 <= mem1[rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Draw pipeline: S0 registers the pixel and RAM address, S1 overlays
    // ------------------------------------------------------------------
    logic [7:0]  rd_data;
    logic [10:0] y, y_ref, y_lo, y_hi, y_prev_q;
    logic        s0_active, s0_in_col, lit;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0     <= '0;
            rd_sel <= 1'b0;
        end else begin
            s0     <= pixel_t'{in.hcount, in.vcount, in.hsync, in.vsync,
                               in.hblnk, in.vblnk, in.rgb};
            rd_sel <= ptr_q;
        end
    end

    always_comb begin
        rd_data   = rd_sel ? rd1 : rd0;
        y         = 11'(Y_OFF) + 11'd255 - 11'(rd_data);
        // Column 0 has no left neighbour: draw a single pixel.
        y_ref     = (s0.hcount == 11'd0) ? y : y_prev_q;
        y_lo      = (y_ref < y) ? y_ref : y;
        y_hi      = (y_ref < y) ? y : y_ref;
        s0_active = !s0.hblnk && !s0.vblnk;
        s0_in_col = s0.hcount < 11'(NSAMPLES);
        lit       = s0_active && fv_q && s0_in_col &&
                    s0.vcount >= y_lo && s0.vcount <= y_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
            y_prev_q   <= '0;
        end else begin
            out.hcount <= s0.hcount;
            out.vcount <= s0.vcount;
            out.hsync  <= s0.hsync;
            out.vsync  <= s0.vsync;
            out.hblnk  <= s0.hblnk;
            out.vblnk  <= s0.vblnk;
            out.rgb    <= lit ? TRACE_RGB : s0.rgb;
            if (s0_active && s0_in_col) begin
                y_prev_q <= y;
            end
        end
    end

endmodule

// File: tb/tb_draw_wave.sv
// tb_draw_wave: self-checking bench for draw_wave with a reduced record
// length and timeout. Every driven pixel pushes its expected output onto a
// scoreboard queue that is popped two clocks later; trig_seen is compared
// each clock against a behavioural model of the capture sequence.
module tb_draw_wave;

    localparam int          N     = 16;
    localparam int          AT    = 20;
    localparam int          YOFF  = 150;
    localparam logic [11:0] TRACE = 12'h0f0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_data = 8'h00;
    logic [7:0] trig_level = 8'h80;
    logic       hold = 1'b0;
    logic       trig_seen;

    vga_if vin ();
    vga_if vout ();

    always #5 clk = ~clk;

    draw_wave #(
        .NSAMPLES    (N),
        .Y_OFF       (YOFF),
        .TRACE_RGB   (TRACE),
        .AUTO_TIMEOUT(AT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (vin),
        .out         (vout),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .trig_level  (trig_level),
        .hold        (hold),
        .trig_seen   (trig_seen)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [37:0] exp_q[$];
    int          m_state;          // 0 ARM, 1 WAIT_TRIG, 2 CAPTURE, 3 FULL
    logic [7:0]  m_prev;
    int          m_cnt, m_wr;
    logic [7:0]  m_back [N];
    logic [7:0]  m_front[N];
    bit          m_fv;
    logic [10:0] m_yprev;
    bit          m_vb_prev;
    bit          exp_trig;
    int          sample_no, last_sno, trig_at;

    function automatic logic [37:0] out_vec();
        return {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                vout.hblnk, vout.vblnk, vout.rgb};
    endfunction

    task automatic model_reset();
        m_state   = 0;
        m_prev    = 8'h00;
        m_cnt     = 0;
        m_wr      = 0;
        m_fv      = 1'b0;
        m_yprev   = '0;
        m_vb_prev = 1'b0;
        exp_trig  = 1'b0;
    endtask

    task automatic model_pixel(input logic [10:0] hc, input logic [10:0] vc,
                               input logic hb, input logic vb, input logic [11:0] rgb,
                               output logic [37:0] e);
        logic [10:0] y, yr, lo, hi;
        bit active, lit;
        active = !hb && !vb;
        lit    = 1'b0;
        if (hc < 11'(N)) begin
            y  = 11'(YOFF) + 11'd255 - 11'(m_front[hc[3:0]]);
            yr = (hc == 11'd0) ? y : m_yprev;
            lo = (yr < y) ? yr : y;
            hi = (yr < y) ? y : yr;
            lit = active && m_fv && vc >= lo && vc <= hi;
            if (active) m_yprev = y;
        end
        e = {hc, vc, hb, vb, hb, vb, lit ? TRACE : rgb};
    endtask

    task automatic model_update(input bit sv, input logic [7:0] sd, input bit vb);
        bit rise;
        rise      = vb && !m_vb_prev;
        m_vb_prev = vb;
        exp_trig  = 1'b0;
        case (m_state)
            0: if (sv) begin m_prev = sd; m_cnt = 0; m_state = 1; end
            1: if (sv) begin
                if ((m_prev < trig_level && sd >= trig_level) || m_cnt == AT - 1) begin
                    m_back[0] = sd;
                    m_wr      = 1;
                    exp_trig  = 1'b1;
                    m_state   = 2;
                end else begin
                    m_cnt++;
                end
                m_prev = sd;
            end
            2: if (sv) begin
                m_back[m_wr] = sd;
                if (m_wr == N - 1) m_state = 3;
                m_wr++;
            end
            default: if (rise && !hold) begin
                for (int i = 0; i < N; i++) m_front[i] = m_back[i];
                m_fv    = 1'b1;
                m_state = 0;
            end
        endcase
    endtask

    // One clock: check what is due, then drive the next pixel and sample.
    task automatic step(input logic [10:0] hc, input logic [10:0] vc, input logic hb,
                        input logic vb, input logic [11:0] rgb, input bit sv,
                        input logic [7:0] sd);
        logic [37:0] e;
        @(posedge clk);
        #1;
        check("trig_seen", 64'(trig_seen), 64'(exp_trig));
        if (trig_seen === 1'b1) trig_at = last_sno;
        if (exp_q.size() >= 2) check("pixel", 64'(out_vec()), 64'(exp_q.pop_front()));
        vin.hcount   = hc;
        vin.vcount   = vc;
        vin.hsync    = hb;
        vin.vsync    = vb;
        vin.hblnk    = hb;
        vin.vblnk    = vb;
        vin.rgb      = rgb;
        sample_valid = sv;
        sample_data  = sd;
        if (sv) sample_no++;
        last_sno = sample_no;
        model_pixel(hc, vc, hb, vb, rgb, e);
        exp_q.push_back(e);
        model_update(sv, sd, vb);
    endtask

    task automatic do_reset(input int cycles);
        rst          = 1'b1;
        sample_valid = 1'b0;
        vin.hcount   = 11'd3;
        vin.vcount   = 11'd7;
        vin.hsync    = 1'b1;
        vin.vsync    = 1'b0;
        vin.hblnk    = 1'b0;
        vin.vblnk    = 1'b0;
        vin.rgb      = 12'h888;
        exp_q.delete();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check("rst_out", 64'(out_vec()), 64'd0);
            check("rst_trig", 64'(trig_seen), 64'd0);
        end
        model_reset();
        rst = 1'b0;
    endtask

    task automatic feed(input logic [7:0] sd);
        step(11'd900, 11'd600, 1'b1, 1'b0, 12'($urandom), 1'b1, sd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(11'd900, 11'd600, 1'b1, 1'b0, 12'($urandom), 1'b0, 8'h00);
    endtask

    task automatic vblank_edge();
        step(11'd0, 11'd500, 1'b1, 1'b0, 12'h321, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++)
            step(11'(i), 11'd500, 1'b0, 1'b1, 12'h654, 1'b0, 8'h00);
        step(11'd0, 11'd501, 1'b1, 1'b0, 12'h987, 1'b0, 8'h00);
    endtask

    // Active columns 0..N+1 (the last two lie beyond the record), then hblnk.
    task automatic line(input logic [10:0] vc);
        for (int c = 0; c < N + 2; c++)
            step(11'(c), vc, 1'b0, 1'b0, 12'h800 + 12'(c), 1'b0, 8'h00);
        step(11'd5, vc, 1'b1, 1'b0, 12'habc, 1'b0, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin m_front[i] = 8'h00; m_back[i] = 8'h00; end
        sample_no = 0;
        last_sno  = 0;
        trig_at   = -1;
        model_reset();

        // Reset, then pass-through with no trace before the first swap.
        do_reset(3);
        for (int c = 0; c < 4; c++)
            step(11'(c), 11'd277, 1'b0, 1'b0, 12'h888, 1'b0, 8'h00);

        // Rising ramp trigger at 0x80; two extra samples land in FULL.
        trig_level = 8'h80;
        feed(8'h7E);
        feed(8'h7F);
        for (int i = 0; i < N; i++) feed(8'h80 + 8'(i));
        feed(8'h00);
        feed(8'hFF);
        idle(2);
        vblank_edge();
        line(11'd277);
        line(11'd276);
        line(11'd262);

        // Segment record: index 9 = 0x00, index 10 = 0x10.
        feed(8'h00);
        feed(8'h80);
        for (int i = 1; i <= 8; i++) feed(8'h40);
        feed(8'h00);
        feed(8'h10);
        for (int i = 11; i < N; i++) feed(8'h20);
        hold = 1'b1;
        vblank_edge();
        line(11'd277);
        vblank_edge();
        line(11'd277);
        hold = 1'b0;
        vblank_edge();
        line(11'd389);
        line(11'd388);
        line(11'd397);
        line(11'd405);

        // Auto trigger on a constant input below the threshold.
        sample_no = 0;
        trig_at   = -1;
        for (int i = 0; i < AT + N; i++) feed(8'h20);
        idle(2);
        check("auto_trig_at", 64'(trig_at), 64'(AT + 1));
        vblank_edge();
        line(11'd373);
        line(11'd372);

        // Reset mid-capture: nothing drawn until a full new record swaps in.
        feed(8'h00);
        feed(8'hF0);
        for (int i = 0; i < 5; i++) feed(8'hF0);
        do_reset(2);
        line(11'd373);
        vblank_edge();
        line(11'd373);
        feed(8'h00);
        feed(8'hF0);
        for (int i = 1; i < N; i++) feed(8'hF0);
        idle(2);
        vblank_edge();
        line(11'd165);
        line(11'd373);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
